// File: rtl/cu_instr_issuer.sv
// cu_instr_issuer: byte-serially loaded program buffer that issues one 16-bit
// instruction per clock to a compute unit and captures the 8-bit results,
// tagging each result with the program index it belongs to.
module cu_instr_issuer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_byte,
    input  logic              clear,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   prog_len,
    output logic              cu_ena,
    output logic [15:0]       cu_instr,
    input  logic [7:0]        cu_result,
    output logic              res_valid,
    output logic [7:0]        res_data,
    output logic [ADDR_W-1:0] res_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(DEPTH);

    state_t              state_reg, state_next;
    logic [ADDR_W:0]     prog_len_reg;
    logic [ADDR_W:0]     ptr_reg;
    logic                phase_reg;      // 0: expecting high byte, 1: expecting low byte
    logic [7:0]          hi_byte_reg;
    logic [15:0]         mem [DEPTH];
    logic                cu_ena_reg;
    logic [15:0]         cu_instr_reg;
    logic [ADDR_W-1:0]   cu_idx_reg;
    logic                d1_valid_reg;
    logic [ADDR_W-1:0]   d1_idx_reg;
    logic                res_valid_reg;
    logic [7:0]          res_data_reg;
    logic [ADDR_W-1:0]   res_idx_reg;
    logic                done_reg;

    logic                is_idle;
    logic                wr_fire;
    logic                start_go;
    logic                issue_more;
    logic [ADDR_W-1:0]   rd_addr;

    assign is_idle    = (state_reg == IDLE);
    assign wr_ready   = is_idle && (prog_len_reg < FULL_LEN) && !start;
    // clear takes priority over a byte offered in the same cycle
    assign wr_fire    = wr_valid && wr_ready && !clear;
    // clear wins over start when both are asserted
    assign start_go   = is_idle && start && !clear;
    assign issue_more = (ptr_reg < prog_len_reg);
    // first word is read while still in IDLE; afterwards the issue pointer drives the read
    assign rd_addr    = is_idle ? '0 : ptr_reg[ADDR_W-1:0];

    assign busy      = !is_idle;
    assign done      = done_reg;
    assign prog_len  = prog_len_reg;
    assign cu_ena    = cu_ena_reg;
    assign cu_instr  = cu_instr_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_idx   = res_idx_reg;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic: RUN until the pointer reaches prog_len, DRAIN until results are out
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_go && (prog_len_reg != '0)) state_next = RUN;
            RUN:     if (!issue_more) state_next = DRAIN;
            DRAIN:   if (!d1_valid_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Program buffer write port: a word is stored once its low byte arrives
    always_ff @(posedge clk) begin
        if (wr_fire && phase_reg)
            mem[prog_len_reg[ADDR_W-1:0]] <= {hi_byte_reg, wr_byte};
    end

    // Loader bookkeeping: byte phase, pending high byte and committed length
    always_ff @(posedge clk) begin
        if (rst) begin
            prog_len_reg <= '0;
            phase_reg    <= 1'b0;
            hi_byte_reg  <= '0;
        end else if (is_idle && clear) begin
            prog_len_reg <= '0;
            phase_reg    <= 1'b0;
        end else if (start_go) begin
            phase_reg    <= 1'b0;
        end else if (wr_fire) begin
            if (!phase_reg) begin
                hi_byte_reg <= wr_byte;
                phase_reg   <= 1'b1;
            end else begin
                prog_len_reg <= prog_len_reg + 1'b1;
                phase_reg    <= 1'b0;
            end
        end
    end

    // Issue stage: registered read of the buffer straight onto the compute-unit bus
    always_ff @(posedge clk) begin
        if (rst) begin
            cu_ena_reg   <= 1'b0;
            cu_instr_reg <= '0;
            cu_idx_reg   <= '0;
            ptr_reg      <= '0;
        end else if ((start_go && (prog_len_reg != '0)) ||
                     (state_reg == RUN && issue_more)) begin
            cu_ena_reg   <= 1'b1;
            cu_instr_reg <= mem[rd_addr];
            cu_idx_reg   <= rd_addr;
            ptr_reg      <= (is_idle ? '0 : ptr_reg) + 1'b1;
        end else begin
            cu_ena_reg   <= 1'b0;
            cu_instr_reg <= '0;
            if (is_idle) ptr_reg <= '0;
        end
    end

    // Two-stage (valid, idx) delay line matching the compute unit's one-cycle latency
    always_ff @(posedge clk) begin
        if (rst) begin
            d1_valid_reg  <= 1'b0;
            d1_idx_reg    <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_idx_reg   <= '0;
        end else begin
            d1_valid_reg  <= cu_ena_reg;
            d1_idx_reg    <= cu_idx_reg;
            res_valid_reg <= d1_valid_reg;
            if (d1_valid_reg) begin
                res_data_reg <= cu_result;
                res_idx_reg  <= d1_idx_reg;
            end
        end
    end

    // Completion pulse: empty-program start, or the drain finishing
    always_ff @(posedge clk) begin
        if (rst) done_reg <= 1'b0;
        else     done_reg <= (start_go && (prog_len_reg == '0)) ||
                             (state_reg == DRAIN && !d1_valid_reg);
    end

endmodule

// File: tb/tb_cu_instr_issuer.sv
// Directed testbench for cu_instr_issuer with a small registered compute-unit model.
module tb_cu_instr_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_byte = '0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [4:0]  prog_len;
    logic        cu_ena;
    logic [15:0] cu_instr;
    logic [7:0]  cu_result = '0;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [3:0]  res_idx;

    int errors = 0;
    int checks = 0;

    cu_instr_issuer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_byte(wr_byte),
        .clear(clear), .start(start), .busy(busy), .done(done),
        .prog_len(prog_len), .cu_ena(cu_ena), .cu_instr(cu_instr),
        .cu_result(cu_result), .res_valid(res_valid),
        .res_data(res_data), .res_idx(res_idx)
    );

    always #5 clk = ~clk;

    // Compute-unit model: op 1 passes the low byte, op 2 multiplies its nibbles, else XOR
    always @(posedge clk) begin
        case (cu_instr[15:12])
            4'h1:    cu_result <= cu_instr[7:0];
            4'h2:    cu_result <= 8'(cu_instr[7:4] * cu_instr[3:0]);
            default: cu_result <= cu_instr[15:8] ^ cu_instr[7:0];
        endcase
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_byte  = b;
        tick();
        wr_valid = 1'b0;
        $display("write byte %02h prog_len=%0d", b, prog_len);
    endtask

    // Runs the 3-word program 1305/1407/2534; optionally pulses clear during RUN
    task automatic run3(input bit clr);
        start = 1'b1;
        tick();
        start = 1'b0;
        clear = clr;
        chk("r3_c0_ena", cu_ena, 1);
        chk("r3_c0_instr", cu_instr, 16'h1305);
        chk("r3_c0_busy", busy, 1);
        chk("r3_c0_rv", res_valid, 0);
        tick();
        clear = 1'b0;
        chk("r3_c1_instr", cu_instr, 16'h1407);
        chk("r3_c1_ena", cu_ena, 1);
        chk("r3_c1_rv", res_valid, 0);
        tick();
        chk("r3_c2_instr", cu_instr, 16'h2534);
        chk("r3_c2_rv", res_valid, 1);
        chk("r3_c2_data", res_data, 8'h05);
        chk("r3_c2_idx", res_idx, 0);
        tick();
        chk("r3_c3_ena", cu_ena, 0);
        chk("r3_c3_instr", cu_instr, 0);
        chk("r3_c3_data", res_data, 8'h07);
        chk("r3_c3_idx", res_idx, 1);
        chk("r3_c3_busy", busy, 1);
        tick();
        chk("r3_c4_rv", res_valid, 1);
        chk("r3_c4_data", res_data, 8'h0C);
        chk("r3_c4_idx", res_idx, 2);
        chk("r3_c4_done", done, 0);
        tick();
        chk("r3_c5_done", done, 1);
        chk("r3_c5_rv", res_valid, 0);
        chk("r3_c5_busy", busy, 0);
        tick();
        chk("r3_c6_done", done, 0);
        chk("r3_len", prog_len, 3);
        $display("run3 clear_during_run=%0d complete", clr);
    endtask

    initial begin
        int accepted;
        int seen;
        logic [7:0] prog [6];

        // Reset state
        @(negedge clk);
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_len", prog_len, 0);
        chk("rst_ena", cu_ena, 0);
        chk("rst_instr", cu_instr, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_rdata", res_data, 0);
        chk("rst_ridx", res_idx, 0);
        rst = 1'b0;
        chk("rst_wr_ready", wr_ready, 1);

        // Load and run a 3-word program, then replay it with clear pulsed mid-run
        prog = '{8'h13, 8'h05, 8'h14, 8'h07, 8'h25, 8'h34};
        for (int i = 0; i < 6; i++) wr(prog[i]);
        chk("load_len", prog_len, 3);
        run3(1'b0);
        run3(1'b1);

        // Empty program: done next cycle, nothing issued
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_len", prog_len, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_done", done, 1);
        chk("empty_ena", cu_ena, 0);
        chk("empty_busy", busy, 0);
        tick();
        chk("empty_done_off", done, 0);
        chk("empty_rv", res_valid, 0);
        chk("empty_ena2", cu_ena, 0);
        $display("empty program start complete");

        // Overfill: 33 bytes offered, 32 accepted
        accepted = 0;
        for (int i = 0; i < 33; i++) begin
            wr_valid = 1'b1;
            wr_byte  = 8'(i);
            if (wr_ready) accepted++;
            tick();
        end
        wr_valid = 1'b0;
        chk("full_accepted", accepted, 32);
        chk("full_len", prog_len, 16);
        chk("full_wr_ready", wr_ready, 0);
        $display("overfill accepted=%0d prog_len=%0d", accepted, prog_len);

        // clear and start together: clear wins, no run, no done
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        chk("cs_len", prog_len, 0);
        chk("cs_busy", busy, 0);
        chk("cs_ena", cu_ena, 0);
        chk("cs_done", done, 0);
        $display("clear+start complete");

        // Two words plus a dangling byte: exactly two issued, phase back to high
        wr(8'hAA); wr(8'hBB); wr(8'hCC); wr(8'hDD); wr(8'hEE);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("p2_c0_instr", cu_instr, 16'hAABB);
        tick();
        chk("p2_c1_instr", cu_instr, 16'hCCDD);
        tick();
        chk("p2_c2_ena", cu_ena, 0);
        chk("p2_c2_instr", cu_instr, 0);
        chk("p2_len", prog_len, 2);
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            tick();
            if (done) seen = 1;
        end
        chk("p2_done_seen", seen, 1);
        wr(8'h11);
        chk("p2_phase_hi", prog_len, 2);
        wr(8'h22);
        chk("p2_len3", prog_len, 3);

        // Reset mid-run of a 4-word program
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 1; i <= 8; i++) wr(8'(i));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mr_c0_instr", cu_instr, 16'h0102);
        tick();
        chk("mr_c1_instr", cu_instr, 16'h0304);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_ena", cu_ena, 0);
        chk("mr_instr", cu_instr, 0);
        chk("mr_rv", res_valid, 0);
        chk("mr_len", prog_len, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (res_valid || done || cu_ena) seen++;
        end
        chk("mr_quiet", seen, 0);
        $display("reset mid-run complete");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
